// File: rtl/bsg_hold_time_test_driver.sv
// Tester-side driver for the hold-time test chip: writes an LFSR payload to all
// entries of the chip memory, reads them back and checks the returned words.
module bsg_hold_time_test_driver #(
  parameter int width_p        = 34,
  parameter int els_p          = 64,
  parameter int read_latency_p = 3
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               start_i,
  input  logic [19:0]        seed_i,
  output logic [width_p-1:0] data_o,
  input  logic [width_p-1:0] data_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [15:0]        err_cnt_o,
  output logic [5:0]         first_err_addr_o
);

  localparam int          addr_w_lp   = 6;
  localparam int          head_lp     = read_latency_p - 1;
  localparam logic [5:0]  last_cnt_lp = addr_w_lp'(els_p - 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_e;

  function automatic logic [19:0] lfsr_step(input logic [19:0] l);
    return {l[18:0], l[19] ^ l[16]};
  endfunction

  function automatic logic [width_p-1:0] write_word(input logic [19:0] l,
                                                    input logic [5:0] a);
    return {l, 6'b0, 1'b0, a, 1'b1};
  endfunction

  function automatic logic [width_p-1:0] read_word(input logic [5:0] a);
    return {20'b0, a, 1'b1, 6'b0, 1'b0};
  endfunction

  state_e               state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [19:0]          lfsr_q, lfsr_d;
  logic [19:0]          seed_q, seed_d;
  logic [15:0]          err_cnt_q, err_cnt_d;
  logic [5:0]           first_q, first_d;
  logic [width_p-1:0]   data_q, data_d;
  logic                 busy_q, done_q, pass_q;

  // Expected-response pipe: stage 0 is pushed at the end of each READ cycle,
  // the head lines up with the chip's returned word.
  logic [read_latency_p-1:0] pipe_v_q;
  logic [5:0]                pipe_addr_q [read_latency_p];
  logic [width_p-1:0]        pipe_exp_q  [read_latency_p];

  logic                 push_v;
  logic                 head_mismatch;
  logic [19:0]          seed_fix;

  assign seed_fix      = (seed_i == 20'd0) ? 20'd1 : seed_i;
  assign push_v        = (state_q == READ);
  assign head_mismatch = pipe_v_q[head_lp] && (data_i != pipe_exp_q[head_lp]);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    seed_d    = seed_q;
    err_cnt_d = err_cnt_q;
    first_d   = first_q;

    if (head_mismatch) begin
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      if (err_cnt_q == 16'd0)    first_d   = pipe_addr_q[head_lp];
    end

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d   = WRITE;
          cnt_d     = '0;
          lfsr_d    = seed_fix;
          seed_d    = seed_fix;
          err_cnt_d = '0;
          first_d   = '0;
        end
      end
      WRITE: begin
        cnt_d  = cnt_q + 6'd1;
        lfsr_d = lfsr_step(lfsr_q);
        if (cnt_q == last_cnt_lp) begin
          state_d = READ;
          cnt_d   = '0;
          lfsr_d  = seed_q;
        end
      end
      READ: begin
        cnt_d  = cnt_q + 6'd1;
        lfsr_d = lfsr_step(lfsr_q);
        if (cnt_q == last_cnt_lp) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        if (pipe_v_q == '0) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    // data_o is registered, so it is built from the state of the coming cycle.
    case (state_d)
      WRITE:   data_d = write_word(lfsr_d, cnt_d);
      READ:    data_d = read_word(cnt_d);
      default: data_d = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lfsr_q    <= '0;
      seed_q    <= '0;
      err_cnt_q <= '0;
      first_q   <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      pipe_v_q  <= '0;
      // NOTE: the pipe payload is reset too, so an aborted pass leaves no
      // stale expectation that could be compared after the next start.
      for (int i = 0; i < read_latency_p; i++) begin
        pipe_addr_q[i] <= '0;
        pipe_exp_q[i]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      seed_q    <= seed_d;
      err_cnt_q <= err_cnt_d;
      first_q   <= first_d;
      data_q    <= data_d;
      busy_q    <= (state_d == WRITE) || (state_d == READ) || (state_d == DRAIN);
      done_q    <= (state_d == DONE);
      pass_q    <= (state_d == DONE) && (err_cnt_d == 16'd0);

      for (int i = read_latency_p - 1; i > 0; i--) begin
        pipe_v_q[i]    <= pipe_v_q[i-1];
        pipe_addr_q[i] <= pipe_addr_q[i-1];
        pipe_exp_q[i]  <= pipe_exp_q[i-1];
      end
      pipe_v_q[0]    <= push_v;
      pipe_addr_q[0] <= cnt_q;
      pipe_exp_q[0]  <= write_word(lfsr_q, cnt_q);
    end
  end

  assign data_o           = data_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign err_cnt_o        = err_cnt_q;
  assign first_err_addr_o = first_q;

endmodule
